// File: rtl/pll_usb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_usb_pkg
// Brief    : Shared types and defaults for the USB PLL lock sequencer.
// Revision : 1.0
// ============================================================================
package pll_usb_pkg;

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } pll_seq_state_t;

    localparam int LOCK_LOST_CNT_W         = 8;
    localparam int DEF_RST_CYCLES          = 32;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_CNT_W               = 17;

    function automatic logic [LOCK_LOST_CNT_W-1:0] sat_inc(
        input logic [LOCK_LOST_CNT_W-1:0] v
    );
        return (&v) ? v : v + LOCK_LOST_CNT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_usb_lock_ctrl_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Generic two-flop single-bit synchronizer, resets to 0.
// Revision : 1.0
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_usb_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pll_usb_lock_ctrl
// Brief    : Sequences the 12 MHz USB PLL reset, lock wait and debounce, then
//            releases the USB domain. Macro PLL_USB_LOCK_LOSS_CNT_EN builds
//            the saturating lock-loss counter.
// Revision : 1.0
// ============================================================================
module pll_usb_lock_ctrl
    import pll_usb_pkg::*;
#(
    parameter int RST_CYCLES          = DEF_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       pll_locked_i,
    input  logic                       relock_req_i,
    output logic                       pll_rst_o,
    output logic                       usb_reset_n_o,
    output logic                       ready_o,
    output logic                       timeout_o,
    output logic [LOCK_LOST_CNT_W-1:0] lock_lost_cnt_o
);

    localparam logic [CNT_W-1:0] c_rst_last     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_stable_last  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    pll_seq_state_t   r_state;
    pll_seq_state_t   w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_lock_s;
    logic             w_timeout_set;

    sync_2ff u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (pll_locked_i),
        .o_q     (w_lock_s)
    );

    // Relock has priority over every lock-driven transition outside RESET_PLL.
    always_comb begin
        w_state_nxt   = r_state;
        w_timeout_set = 1'b0;
        case (r_state)
            RESET_PLL: begin
                if (r_cnt == c_rst_last) w_state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (relock_req_i) begin
                    w_state_nxt = RESET_PLL;
                end else if (w_lock_s) begin
                    w_state_nxt = STABILIZE;
                end else if (r_cnt == c_timeout_last) begin
                    w_state_nxt   = RESET_PLL;
                    w_timeout_set = 1'b1;
                end
            end
            STABILIZE: begin
                if (relock_req_i)                w_state_nxt = RESET_PLL;
                else if (!w_lock_s)              w_state_nxt = WAIT_LOCK;
                else if (r_cnt == c_stable_last) w_state_nxt = RUN;
            end
            RUN: begin
                if (relock_req_i || !w_lock_s) w_state_nxt = RESET_PLL;
            end
            default: w_state_nxt = RESET_PLL;
        endcase
    end

    // Outputs are decoded from the next state so they move with the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= RESET_PLL;
            r_cnt         <= '0;
            pll_rst_o     <= 1'b1;
            usb_reset_n_o <= 1'b0;
            ready_o       <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_state != RUN) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            pll_rst_o     <= (w_state_nxt == RESET_PLL);
            usb_reset_n_o <= (w_state_nxt == RUN);
            ready_o       <= (w_state_nxt == RUN);
            if (w_state_nxt == RUN) begin
                timeout_o <= 1'b0;
            end else if (w_timeout_set) begin
                timeout_o <= 1'b1;
            end
        end
    end

`ifdef PLL_USB_LOCK_LOSS_CNT_EN
    logic [LOCK_LOST_CNT_W-1:0] r_lock_lost_cnt;
    logic                       w_loss_evt;

    // A simultaneous relock is a deliberate restart, not a loss.
    assign w_loss_evt = (r_state == RUN) && !w_lock_s && !relock_req_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_lost_cnt <= '0;
        end else if (w_loss_evt) begin
            r_lock_lost_cnt <= sat_inc(r_lock_lost_cnt);
        end
    end

    assign lock_lost_cnt_o = r_lock_lost_cnt;
`else
    assign lock_lost_cnt_o = '0;
`endif

endmodule
`default_nettype wire
